packet_source: RTL
==================

// Module: packet_source
// PURPOSE
//  Traffic generator that drives a flit channel directly into the rx/packet_sink stage.
//  Emits fixed-length packets of PKT_FLITS flits over a 4-phase req/ack handshake.
//  Packets carry a head flit (sequence + destination) and deterministic body flits,
//  so the sink side can check every flit it receives. Used as the NoC test-bench source.
// PARAMETERS
//  SIZE        8   flit width (bits); must exceed DEST_BITS
//  DEST_BITS   3   destination field width in head flit
//  DEST        0   destination address placed in head flit
//  PKT_FLITS   4   flits per packet incl. head (>=1)
//  GAP_CYCLES  2   idle cycles between packets (0 allowed)
//  MAX_PKTS    0   stop after this many packets; 0 = unlimited
//  COUNT_BITS  16  width of pkt_count
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  reset      in   1            synchronous reset, active-low
//  enable     in   1            allow new packets to start
//  ch_req     out  1            channel request (flit valid)
//  ch_flit    out  SIZE         channel flit data
//  ch_ack     in   1            channel acknowledge from receiver
//  busy       out  1            1 while a packet or inter-packet gap is in progress
//  pkt_count  out  COUNT_BITS   packets fully sent (wraps at 2**COUNT_BITS)
// BEHAVIOUR
//  - Reset (reset==0 at edge): ch_req=0, ch_flit=0, busy=0, pkt_count=0, flit_idx=0, state IDLE.
//    Applies mid-packet too: req drops at that edge, packet is abandoned, not counted.
//  - Handshake (4-phase): ch_flit stable whenever ch_req=1; req 0->1, wait ack=1,
//    req 1->0, wait ack=0, then next flit. ch_flit never changes while ch_req=1.
//  - Flit format, seq = pkt_count[SIZE-DEST_BITS-1:0]:
//    head  = {seq, DEST[DEST_BITS-1:0]};  body i (1..PKT_FLITS-1) = (seq + i) mod 2**SIZE.
//  - FSM:
//    IDLE : if enable && (MAX_PKTS==0 || pkt_count<MAX_PKTS): ch_flit<=head,
//           ch_req<=1, flit_idx<=0, busy<=1 -> SEND. Else stay.
//           ch_req rises on the edge after enable is sampled high.
//    SEND : on edge with ch_ack==1: ch_req<=0 -> RELEASE. Otherwise hold.
//    RELEASE: on edge with ch_ack==0:
//           if flit_idx==PKT_FLITS-1: pkt_count<=pkt_count+1;
//             GAP_CYCLES>0 -> GAP (gap_cnt<=GAP_CYCLES-1); else -> IDLE, busy<=0.
//           else flit_idx<=flit_idx+1, ch_flit<=next body, ch_req<=1 -> SEND.
//    GAP  : gap_cnt decrements each edge; at 0 -> IDLE, busy<=0.
//  - enable is sampled only in IDLE; deasserting mid-packet lets the packet complete.
//  - MAX_PKTS reached: stays IDLE with busy=0, ch_req=0, regardless of enable.
//  - pkt_count wraps silently; with MAX_PKTS=0 the comparison is skipped.
//  - ack already high on entry to SEND (protocol error) is treated as a normal ack.
//  - PKT_FLITS==1: packet is head only; count increments after its single handshake.
// CONFIGURATION
//  PACKET_SOURCE_TRACE_EN defined: each completed flit handshake prints
//    $display("%t packet_source: pkt %0d flit %0d = %h", ...); packet completion also printed.
//  Not defined: no display code compiled; RTL behaviour identical in both cases.
// TESTING
//  1 reset=0 for 3 cycles with enable=1 -> ch_req=0, ch_flit=0, pkt_count=0, busy=0 throughout.
//  2 defaults, DEST=5, ack tracks req with 1-cycle delay -> flits 0x05,0x01,0x02,0x03,
//    then 0x0D,0x02,0x03,0x04; pkt_count=1 after first packet's 4th handshake completes.
//  3 ack held low 10 cycles during SEND -> ch_req stays 1, ch_flit unchanged; resumes on ack.
//  4 enable dropped after head flit -> remaining 3 flits still sent, then IDLE, no new head.
//  5 MAX_PKTS=2, enable=1 forever -> exactly 8 handshakes, pkt_count=2, busy=0, req stays 0.
//  6 reset=0 asserted in SEND of flit 2 -> ch_req=0 next edge; after release head is 0x05, count 0.

Source files
------------

// File: rtl/packet_source.sv
// rtl/packet_source.sv - fixed-length packet generator over a 4-phase req/ack flit channel
// Optional PACKET_SOURCE_TRACE_EN prints every completed flit handshake and packet.
module packet_source #(
  parameter int SIZE       = 8,
  parameter int DEST_BITS  = 3,
  parameter int DEST       = 0,
  parameter int PKT_FLITS  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_PKTS   = 0,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  ch_req,
  output logic [SIZE-1:0]       ch_flit,
  input  logic                  ch_ack,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] pkt_count
);

  localparam int SEQ_W = SIZE - DEST_BITS;
  localparam int IDX_W = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DEST_BITS-1:0] DEST_V = DEST[DEST_BITS-1:0];

  typedef enum logic [1:0] {IDLE, SEND, RELEASE, GAP} state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        flit_idx, idx_next;
  logic [GAP_W-1:0]        gap_cnt, gap_next;
  logic                    req_next, busy_next;
  logic [SIZE-1:0]         flit_next;
  logic [COUNT_BITS-1:0]   count_next;

  logic [SEQ_W-1:0]        seq;
  logic [SIZE-1:0]         seq_ext, head_flit, body_flit;
  logic                    quota_ok, start, last_flit, gap_done;

  generate
    if (COUNT_BITS >= SEQ_W) begin : g_seq_slice
      assign seq = pkt_count[SEQ_W-1:0];
    end else begin : g_seq_ext
      assign seq = SEQ_W'(pkt_count);
    end
    if (MAX_PKTS == 0) begin : g_unlimited
      assign quota_ok = 1'b1;
    end else begin : g_limited
      assign quota_ok = pkt_count < COUNT_BITS'(MAX_PKTS);
    end
  endgenerate

  // Body flit i carries seq+i, so the next body after flit_idx is seq+flit_idx+1.
  assign seq_ext   = SIZE'(seq);
  assign head_flit = {seq, DEST_V};
  assign body_flit = seq_ext + SIZE'(flit_idx) + SIZE'(1);
  assign start     = enable && quota_ok;
  assign last_flit = (flit_idx == IDX_W'(PKT_FLITS - 1));
  assign gap_done  = (gap_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEND;
      SEND:    if (ch_ack) state_next = RELEASE;
      RELEASE: begin
        if (!ch_ack) begin
          if (!last_flit)           state_next = SEND;
          else if (GAP_CYCLES > 0)  state_next = GAP;
          else                      state_next = IDLE;
        end
      end
      GAP:     if (gap_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_next   = ch_req;
    flit_next  = ch_flit;
    busy_next  = busy;
    idx_next   = flit_idx;
    gap_next   = gap_cnt;
    count_next = pkt_count;
    case (state)
      IDLE: begin
        if (start) begin
          flit_next = head_flit;
          req_next  = 1'b1;
          idx_next  = '0;
          busy_next = 1'b1;
        end
      end
      SEND: begin
        if (ch_ack) req_next = 1'b0;
      end
      RELEASE: begin
        // New flit data is loaded only together with the rising req, never while req is high.
        if (!ch_ack) begin
          if (last_flit) begin
            count_next = pkt_count + COUNT_BITS'(1);
            if (GAP_CYCLES > 0) gap_next  = GAP_W'(GAP_CYCLES - 1);
            else                busy_next = 1'b0;
          end else begin
            idx_next  = flit_idx + IDX_W'(1);
            flit_next = body_flit;
            req_next  = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_done) busy_next = 1'b0;
        else          gap_next  = gap_cnt - GAP_W'(1);
      end
      default: begin
        req_next  = 1'b0;
        busy_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_req    <= 1'b0;
      ch_flit   <= '0;
      busy      <= 1'b0;
      flit_idx  <= '0;
      gap_cnt   <= '0;
      pkt_count <= '0;
    end else begin
      ch_req    <= req_next;
      ch_flit   <= flit_next;
      busy      <= busy_next;
      flit_idx  <= idx_next;
      gap_cnt   <= gap_next;
      pkt_count <= count_next;
    end
  end

`ifdef PACKET_SOURCE_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && state == RELEASE && !ch_ack) begin
      $display("%t packet_source: pkt %0d flit %0d = %h", $time, pkt_count, flit_idx, ch_flit);
      if (last_flit) $display("%t packet_source: pkt %0d complete", $time, pkt_count);
    end
  end
`else
`endif

endmodule
